ddc_oct_acc: RTL and testbench

Receive-side integrator for the oct DDC output stream. Consumes the 64-bit summed I/Q word produced by the oct DDC (Q in `[61:32]`, I in `[29:0]`, each a sign-extended 30-bit value). Sums a programmable number N of consecutive samples per component. Emits one registered frame result per N samples on an AXI-Stream master, tagged with a frame index, ahead of the DMA/readout path.

---
 rtl/ddc_oct_pkg.sv | 21 ++
 rtl/ddc_acc_lane.sv | 30 +++
 rtl/ddc_oct_acc.sv | 176 +++++++++++++++++
 tb/tb_ddc_oct_acc.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ddc_oct_pkg.sv
// Shared constants and state type for the oct DDC frame integrator.
package ddc_oct_pkg;

  // Component resolution of the oct DDC output and pad up to a 32-bit half-word.
  localparam int unsigned IN_RES = 30;
  localparam int unsigned IN_PAD = 32 - IN_RES;

  // Input word field positions.
  localparam int unsigned Q_LSB = 32;
  localparam int unsigned I_LSB = 0;

  // Config word field positions.
  localparam int unsigned EN_BIT  = 31;
  localparam int unsigned LEN_LSB = 0;

  typedef enum logic [0:0] {
    StIdle,
    StAcc
  } acc_state_e;

endpackage

// File: rtl/ddc_acc_lane.sv
// One signed accumulate lane: sign-extends a sample and either loads or adds it.
module ddc_acc_lane #(
  parameter int unsigned IN_RES = 30,
  parameter int unsigned ACC_W  = 48
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              first_i,
  input  logic [IN_RES-1:0] sample_i,
  output logic [ACC_W-1:0]  sum_o
);

  logic [ACC_W-1:0] acc_q, acc_d, sample_ext;

  assign sample_ext = {{(ACC_W-IN_RES){sample_i[IN_RES-1]}}, sample_i};

  // First sample of a frame replaces the stale partial sum.
  always_comb begin
    sum_o = first_i ? sample_ext : acc_q + sample_ext;
    acc_d = en_i ? sum_o : acc_q;
  end

  // Partial-sum register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

endmodule

// File: rtl/ddc_oct_acc.sv
// Frame integrator for the oct DDC I/Q stream with an AXI-Stream result port.
module ddc_oct_acc
  import ddc_oct_pkg::*;
#(
  parameter int unsigned LEN_W  = 16,
  parameter int unsigned IN_RES = ddc_oct_pkg::IN_RES,
  parameter int unsigned ACC_W  = 48
) (
  input  logic         s_axis_aclk,
  input  logic         s_axis_aresetn,
  input  logic [63:0]  s_axis_ddc_tdata,
  input  logic         s_axis_ddc_tvalid,
  output logic         s_axis_ddc_tready,
  input  logic [31:0]  s_axis_cfg_tdata,
  input  logic         s_axis_cfg_tvalid,
  output logic [127:0] m_axis_acc_tdata,
  output logic [31:0]  m_axis_acc_tuser,
  output logic         m_axis_acc_tvalid,
  input  logic         m_axis_acc_tready,
  output logic         overflow
);

  acc_state_e       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;    // N-1 of the running frame
  logic [LEN_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      fidx_q, fidx_d;
  logic [ACC_W-1:0] out_i_q, out_i_d, out_q_q, out_q_d;
  logic [31:0]      tuser_q, tuser_d;
  logic             tvalid_q, tvalid_d;
  logic             ovf_q, ovf_d;

  logic             cfg_en, abort, accept, first, last, complete;
  logic [LEN_W-1:0] cfg_len;
  logic [ACC_W-1:0] sum_i, sum_q;
  logic             unused_bits;

  assign cfg_en   = s_axis_cfg_tdata[EN_BIT];
  assign cfg_len  = s_axis_cfg_tdata[LEN_LSB +: LEN_W];
  assign abort    = s_axis_cfg_tvalid && !cfg_en;
  assign accept   = (state_q == StAcc) && s_axis_ddc_tvalid && !abort;
  assign first    = (cnt_q == '0);
  assign last     = (cnt_q == len_q);
  assign complete = accept && last;

  assign unused_bits = ^{s_axis_ddc_tdata[63:Q_LSB+IN_RES], s_axis_ddc_tdata[Q_LSB-1:I_LSB+IN_RES],
                         s_axis_cfg_tdata[EN_BIT-1:LEN_LSB+LEN_W]};

  ddc_acc_lane #(.IN_RES(IN_RES), .ACC_W(ACC_W)) u_lane_i (
    .clk_i    (s_axis_aclk),
    .rst_ni   (s_axis_aresetn),
    .en_i     (accept),
    .first_i  (first),
    .sample_i (s_axis_ddc_tdata[I_LSB +: IN_RES]),
    .sum_o    (sum_i)
  );

  ddc_acc_lane #(.IN_RES(IN_RES), .ACC_W(ACC_W)) u_lane_q (
    .clk_i    (s_axis_aclk),
    .rst_ni   (s_axis_aresetn),
    .en_i     (accept),
    .first_i  (first),
    .sample_i (s_axis_ddc_tdata[Q_LSB +: IN_RES]),
    .sum_o    (sum_q)
  );

  // Control FSM, frame counting and output register next-state.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    cnt_d      = cnt_q;
    fidx_d     = fidx_q;
    out_i_d    = out_i_q;
    out_q_d    = out_q_q;
    tuser_d    = tuser_q;
    tvalid_d   = tvalid_q;
    ovf_d      = ovf_q;

    if (tvalid_q && m_axis_acc_tready) tvalid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_axis_cfg_tvalid && cfg_en) begin
          len_d      = cfg_len;
          cnt_d      = '0;
          fidx_d     = '0;
          ovf_d      = 1'b0;
          pend_vld_d = 1'b0;
          state_d    = StAcc;
        end
      end
      StAcc: begin
        if (abort) begin
          cnt_d      = '0;
          pend_vld_d = 1'b0;
          state_d    = StIdle;
        end else begin
          if (accept) begin
            if (last) begin
              cnt_d = '0;
              if (pend_vld_q) begin
                len_d      = pend_q;
                pend_vld_d = 1'b0;
              end
            end else begin
              cnt_d = cnt_q + LEN_W'(1);
            end
          end
          // A write landing on the final sample already sits on the boundary.
          if (s_axis_cfg_tvalid) begin
            if (complete) begin
              len_d      = cfg_len;
              pend_vld_d = 1'b0;
            end else begin
              pend_d     = cfg_len;
              pend_vld_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (complete) begin
      if (!tvalid_q || m_axis_acc_tready) begin
        out_i_d  = sum_i;
        out_q_d  = sum_q;
        tuser_d  = fidx_q;
        tvalid_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
      fidx_d = fidx_q + 32'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
    if (!s_axis_aresetn) begin
      state_q    <= StIdle;
      len_q      <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      cnt_q      <= '0;
      fidx_q     <= '0;
      out_i_q    <= '0;
      out_q_q    <= '0;
      tuser_q    <= '0;
      tvalid_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      cnt_q      <= cnt_d;
      fidx_q     <= fidx_d;
      out_i_q    <= out_i_d;
      out_q_q    <= out_q_d;
      tuser_q    <= tuser_d;
      tvalid_q   <= tvalid_d;
      ovf_q      <= ovf_d;
    end
  end

  assign s_axis_ddc_tready = s_axis_aresetn;
  assign m_axis_acc_tdata  = {{(64-ACC_W){out_q_q[ACC_W-1]}}, out_q_q,
                              {(64-ACC_W){out_i_q[ACC_W-1]}}, out_i_q};
  assign m_axis_acc_tuser  = tuser_q;
  assign m_axis_acc_tvalid = tvalid_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_ddc_oct_acc.sv
// Scoreboard bench for ddc_oct_acc: directed scenarios plus random traffic.
module tb_ddc_oct_acc;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [63:0]  ddc_tdata = '0;
  logic         ddc_tvalid = 1'b0;
  logic         ddc_tready;
  logic [31:0]  cfg_tdata = '0;
  logic         cfg_tvalid = 1'b0;
  logic [127:0] acc_tdata;
  logic [31:0]  acc_tuser;
  logic         acc_tvalid;
  logic         acc_tready = 1'b0;
  logic         ovf;

  always #5 clk = ~clk;

  ddc_oct_acc dut (
    .s_axis_aclk       (clk),
    .s_axis_aresetn    (rst_n),
    .s_axis_ddc_tdata  (ddc_tdata),
    .s_axis_ddc_tvalid (ddc_tvalid),
    .s_axis_ddc_tready (ddc_tready),
    .s_axis_cfg_tdata  (cfg_tdata),
    .s_axis_cfg_tvalid (cfg_tvalid),
    .m_axis_acc_tdata  (acc_tdata),
    .m_axis_acc_tuser  (acc_tuser),
    .m_axis_acc_tvalid (acc_tvalid),
    .m_axis_acc_tready (acc_tready),
    .overflow          (ovf)
  );

  typedef struct {
    logic [127:0] data;
    logic [31:0]  user;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: frame-level view of the integrator.
  bit          m_run;
  int unsigned m_n, m_cnt, m_pn;
  bit          m_pend;
  longint      m_si, m_sq;
  logic [31:0] m_fidx;
  bit          m_occ, m_ovf;

  task automatic model_reset();
    m_run = 0; m_n = 1; m_cnt = 0; m_pn = 1; m_pend = 0;
    m_si = 0; m_sq = 0; m_fidx = 0; m_occ = 0; m_ovf = 0;
    sb.delete();
  endtask

  // One clock cycle of stimulus; model advances with the DUT's edge.
  task automatic cyc(input bit dv, input logic [29:0] i, input logic [29:0] q,
                     input bit cv, input bit en, input int unsigned len, input bit rdy);
    bit     consumed, complete;
    longint si, sq;
    exp_t   e;
    ddc_tdata  = {2'($urandom), q, 2'($urandom), i};
    ddc_tvalid = dv;
    cfg_tdata  = {en, 15'($urandom), 16'(len)};
    cfg_tvalid = cv;
    acc_tready = rdy;
    @(posedge clk);
    consumed = m_occ && rdy;
    complete = 0;
    si = longint'($signed(i));
    sq = longint'($signed(q));
    if (!m_run) begin
      if (cv && en) begin
        m_n = len + 1; m_cnt = 0; m_fidx = 0; m_ovf = 0; m_pend = 0; m_run = 1;
      end
    end else if (cv && !en) begin
      m_run = 0; m_cnt = 0; m_pend = 0;
    end else begin
      if (dv) begin
        if (m_cnt == 0) begin m_si = si; m_sq = sq; end
        else begin m_si += si; m_sq += sq; end
        if (m_cnt == m_n - 1) begin
          complete = 1;
          m_cnt = 0;
          if (m_pend) begin m_n = m_pn; m_pend = 0; end
        end else begin
          m_cnt++;
        end
      end
      if (cv) begin
        if (complete) begin m_n = len + 1; m_pend = 0; end
        else begin m_pn = len + 1; m_pend = 1; end
      end
    end
    if (complete) begin
      if (!m_occ || consumed) begin
        e.data = {64'(m_sq), 64'(m_si)};
        e.user = m_fidx;
        sb.push_back(e);
        m_occ = 1;
      end else begin
        m_ovf = 1;
      end
      m_fidx++;
    end else if (consumed) begin
      m_occ = 0;
    end
    #1;
    chk("overflow", 128'(ovf), 128'(m_ovf));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) cyc(0, '0, '0, 0, 0, 0, rdy);
  endtask

  // Monitor: every handshake must match the oldest expected frame.
  always @(negedge clk) begin
    if (rst_n && acc_tvalid && acc_tready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_output: got tuser %0d data %h, expected no output",
                 acc_tuser, acc_tdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("acc_tdata", acc_tdata, e.data);
        chk("acc_tuser", 128'(acc_tuser), 128'(e.user));
      end
    end
  end

  localparam logic [29:0] MaxPos = 30'h1FFFFFFF;
  localparam logic [29:0] MinNeg = 30'h20000000;

  initial begin
    model_reset();
    #2;
    chk("reset_tdata", acc_tdata, '0);
    chk("reset_tuser", 128'(acc_tuser), '0);
    chk("reset_tvalid", 128'(acc_tvalid), '0);
    chk("reset_overflow", 128'(ovf), '0);
    chk("reset_tready", 128'(ddc_tready), '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("tready_out_of_reset", 128'(ddc_tready), 128'(1));

    // Samples in IDLE are discarded.
    for (int k = 0; k < 3; k++) cyc(1, 30'(k + 1), 30'(k), 0, 0, 0, 1);

    // N=4, I=1..8, Q=-1..-8.
    cyc(1, 30'd99, 30'd99, 1, 1, 3, 1);
    for (int k = 1; k <= 8; k++) cyc(1, 30'(k), 30'(-k), 0, 0, 0, 1);
    idle(3, 1);

    // N=1 at the extremes.
    cyc(0, '0, '0, 1, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 0, 1);
    for (int k = 0; k < 3; k++) cyc(1, MaxPos, MinNeg, 0, 0, 0, 1);
    idle(3, 1);

    // N=2 with the output stalled: first frame held, later frames dropped.
    cyc(0, '0, '0, 1, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 1, 1);
    for (int k = 0; k < 6; k++) cyc(1, 30'(k), 30'(k), 0, 0, 0, 0);
    chk("held_tuser", 128'(acc_tuser), '0);
    chk("held_tvalid", 128'(acc_tvalid), 128'(1));
    chk("stall_overflow", 128'(ovf), 128'(1));
    idle(1, 1);
    for (int k = 0; k < 2; k++) cyc(1, 30'(k + 7), 30'(k), 0, 0, 0, 1);
    idle(2, 1);

    // Pending length change mid-frame, then abort on the final sample.
    cyc(0, '0, '0, 1, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 3, 1);
    cyc(1, 30'd1, 30'd2, 0, 0, 0, 1);
    cyc(1, 30'd3, 30'd4, 0, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 4, 1);
    for (int k = 0; k < 2; k++) cyc(1, 30'(k + 5), 30'(-k), 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) cyc(1, 30'(k + 10), 30'(k), 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) cyc(1, 30'(k + 20), 30'(k), 0, 0, 0, 1);
    cyc(1, 30'd50, 30'd50, 1, 0, 0, 1);
    for (int k = 0; k < 6; k++) cyc(1, 30'(k), 30'(k), 0, 0, 0, 1);

    // Pending write coinciding with the final sample.
    cyc(0, '0, '0, 1, 1, 1, 1);
    cyc(1, 30'd1, 30'd1, 0, 0, 0, 1);
    cyc(1, 30'd2, 30'd2, 1, 1, 2, 1);
    for (int k = 0; k < 6; k++) cyc(1, 30'(k + 3), 30'(k), 0, 0, 0, 1);
    idle(2, 1);

    // Reset in the middle of a frame.
    cyc(0, '0, '0, 1, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 5, 0);
    for (int k = 0; k < 3; k++) cyc(1, 30'(k + 1), 30'(k), 0, 0, 0, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_tdata", acc_tdata, '0);
    chk("midreset_tuser", 128'(acc_tuser), '0);
    chk("midreset_tvalid", 128'(acc_tvalid), '0);
    chk("midreset_overflow", 128'(ovf), '0);
    chk("midreset_tready", 128'(ddc_tready), '0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(1, 30'd7, 30'd7, 0, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 1, 1);
    for (int k = 0; k < 4; k++) cyc(1, 30'(k + 100), 30'(-k), 0, 0, 0, 1);
    idle(2, 1);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      bit cv, en;
      cv = ($urandom_range(39) == 0);
      en = ($urandom_range(5) != 0);
      cyc($urandom_range(3) != 0, 30'($urandom), 30'($urandom), cv, en,
          $urandom_range(6), $urandom_range(4) < 3);
    end
    idle(4, 1);

    // Longest frame at full positive scale.
    cyc(0, '0, '0, 1, 0, 0, 1);
    cyc(0, '0, '0, 1, 1, 65535, 1);
    for (int k = 0; k < 65536; k++) cyc(1, MaxPos, 30'd0, 0, 0, 0, 1);
    chk("long_frame_i", acc_tdata[63:0], 128'(64'd65536 * 64'd536870911));

    idle(5, 1);
    chk("scoreboard_drained", 128'(sb.size()), '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
